// File: rtl/core_msg_receiver.sv
// rtl/core_msg_receiver.sv - per-core message bus receiver: frame parser, instruction assembler, launch control
module core_msg_receiver #(
  parameter int INSTR_SIZE  = 32,
  parameter int BUS_TO_CORE = 8,
  parameter int ADDR_W      = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_valid,
  input  logic [BUS_TO_CORE-1:0] mess_to_core,
  input  logic                   msg_last,
  output logic                   core_ready,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic [INSTR_SIZE-1:0]  imem_wdata,
  output logic                   prog_loaded,
  output logic                   core_start,
  input  logic                   core_halt,
  output logic                   frame_err
);
  localparam int BPW = INSTR_SIZE / BUS_TO_CORE;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BPW - 1);

  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_START = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     len;
  logic [ADDR_W-1:0]     word_cnt;
  logic [BCW-1:0]        beat_cnt;
  logic [INSTR_SIZE-1:0] asm_word;
  logic [INSTR_SIZE-1:0] word_next;
  logic                  take;
  logic [1:0]            hdr_cmd;
  logic [ADDR_W-1:0]     hdr_len;

  assign take    = msg_valid & core_ready;
  assign hdr_cmd = mess_to_core[BUS_TO_CORE-1 -: 2];
  assign hdr_len = mess_to_core[BUS_TO_CORE-3:0];

  // Current beat merged into its lane so the final beat can be written without a bubble
  always_comb begin
    word_next = asm_word;
    for (int i = 0; i < BPW; i++) begin
      if (beat_cnt == BCW'(i))
        word_next[i*BUS_TO_CORE +: BUS_TO_CORE] = mess_to_core;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      core_ready  <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      prog_loaded <= 1'b0;
      core_start  <= 1'b0;
      frame_err   <= 1'b0;
      len         <= '0;
      word_cnt    <= '0;
      beat_cnt    <= '0;
      asm_word    <= '0;
    end else begin
      imem_we    <= 1'b0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          core_ready <= 1'b1;
          if (take) begin
            frame_err <= 1'b0;
            if (!msg_last) begin
              if (hdr_cmd == CMD_LOAD) begin
                prog_loaded <= 1'b0;
                word_cnt    <= '0;
                beat_cnt    <= '0;
                len         <= hdr_len;
                state       <= LOAD;
              end else begin
                frame_err <= 1'b1;
                state     <= DRAIN;
              end
            end else begin
              case (hdr_cmd)
                CMD_LOAD:  frame_err <= 1'b1;
                CMD_START: begin
                  if (prog_loaded) begin
                    core_start <= 1'b1;
                    core_ready <= 1'b0;
                    state      <= RUN;
                  end else begin
                    frame_err <= 1'b1;
                  end
                end
                CMD_ABORT: prog_loaded <= 1'b0;
                default:   ;
              endcase
            end
          end
        end
        LOAD: begin
          if (take) begin
            asm_word <= word_next;
            if (beat_cnt == LAST_BEAT) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt;
              imem_wdata <= word_next;
              beat_cnt   <= '0;
              word_cnt   <= word_cnt + 1'b1;
              if (word_cnt == len) begin
                if (msg_last) begin
                  prog_loaded <= 1'b1;
                  state       <= IDLE;
                end else begin
                  frame_err <= 1'b1;
                  state     <= DRAIN;
                end
              end else if (msg_last) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              // Frame ended mid-word: the partial word is dropped
              if (msg_last) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end
          end
        end
        RUN: begin
          if (core_halt) begin
            core_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (take && msg_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_msg_receiver.sv
// tb/tb_core_msg_receiver.sv - table, directed and randomized frame checks for core_msg_receiver
module tb_core_msg_receiver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msg_valid = 1'b0;
  logic        msg_last = 1'b0;
  logic        core_halt = 1'b0;
  logic [7:0]  mess_to_core = 8'h00;
  logic        core_ready, imem_we, prog_loaded, core_start, frame_err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;

  int n_tests = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int exp_starts = 0;
  int wr_base = 0;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [5:0]  ex_addr[$];
  logic [31:0] ex_data[$];

  typedef struct packed {
    logic [79:0] beats;
    logic [3:0]  n;
    logic [1:0]  nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        prog;
    logic        err;
  } vec_t;
  vec_t vecs[10];

  core_msg_receiver dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .mess_to_core(mess_to_core),
    .msg_last(msg_last), .core_ready(core_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .prog_loaded(prog_loaded), .core_start(core_start),
    .core_halt(core_halt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
      end
      if (core_start) start_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was taken
  task automatic send(input logic [7:0] d, input bit last);
    int guard = 0;
    msg_valid = 1'b1; mess_to_core = d; msg_last = last;
    while (!core_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!core_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got core_ready=0, want 1 within 200 cycles");
    end
    @(negedge clk);
    msg_valid = 1'b0; msg_last = 1'b0;
  endtask

  task automatic idle(input int n);
    msg_valid = 1'b0;
    core_halt = 1'($urandom_range(0, 1));
    repeat (n) @(negedge clk);
    core_halt = 1'b0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string name);
    check($sformatf("%s wr_cnt", name), wr_addr.size() - wr_base, ex_addr.size());
    for (int i = 0; i < ex_addr.size() && wr_base + i < wr_addr.size(); i++) begin
      check($sformatf("%s wr%0d addr", name, i), 32'(wr_addr[wr_base+i]), 32'(ex_addr[i]));
      check($sformatf("%s wr%0d data", name, i), wr_data[wr_base+i], ex_data[i]);
    end
    wr_base = wr_addr.size();
    ex_addr.delete();
    ex_data.delete();
  endtask

  task automatic halt_pulse();
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
  endtask

  initial begin
    bit          m_prog;
    bit          m_err;
    bit          multi;
    int          cmd, len, need, nd, kind, nx, nwr;
    logic [7:0]  hdr;
    logic [7:0]  data[$];

    vecs[0] = '{beats: 80'h00DEADBEEF1234567841, n: 4'd9, nw: 2'd2, w0: 32'h12345678, w1: 32'hDEADBEEF, prog: 1'b1, err: 1'b0};
    vecs[1] = '{beats: 80'h00,                   n: 4'd1, nw: 2'd0, w0: 32'h0,        w1: 32'h0,        prog: 1'b1, err: 1'b0};
    vecs[2] = '{beats: 80'h0080,                 n: 4'd2, nw: 2'd0, w0: 32'h0,        w1: 32'h0,        prog: 1'b1, err: 1'b1};
    vecs[3] = '{beats: 80'hC0,                   n: 4'd1, nw: 2'd0, w0: 32'h0,        w1: 32'h0,        prog: 1'b0, err: 1'b0};
    vecs[4] = '{beats: 80'h66554433221142,       n: 4'd7, nw: 2'd1, w0: 32'h44332211, w1: 32'h0,        prog: 1'b0, err: 1'b1};
    vecs[5] = '{beats: 80'h00,                   n: 4'd1, nw: 2'd0, w0: 32'h0,        w1: 32'h0,        prog: 1'b0, err: 1'b0};
    vecs[6] = '{beats: 80'h050403020140,         n: 4'd6, nw: 2'd1, w0: 32'h04030201, w1: 32'h0,        prog: 1'b0, err: 1'b1};
    vecs[7] = '{beats: 80'hC0,                   n: 4'd1, nw: 2'd0, w0: 32'h0,        w1: 32'h0,        prog: 1'b0, err: 1'b0};
    vecs[8] = '{beats: 80'h41,                   n: 4'd1, nw: 2'd0, w0: 32'h0,        w1: 32'h0,        prog: 1'b0, err: 1'b1};
    vecs[9] = '{beats: 80'hD4C3B2A140,           n: 4'd5, nw: 2'd1, w0: 32'hD4C3B2A1, w1: 32'h0,        prog: 1'b1, err: 1'b0};

    repeat (2) @(negedge clk);
    check("reset outputs", {core_ready, imem_we, prog_loaded, core_start, frame_err, imem_addr}, 32'h0);
    check("reset wdata", imem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready after reset", core_ready, 1);

    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < vecs[v].n; k++)
        send(vecs[v].beats[8*k +: 8], k == vecs[v].n - 1);
      if (vecs[v].nw > 0) begin ex_addr.push_back(6'd0); ex_data.push_back(vecs[v].w0); end
      if (vecs[v].nw > 1) begin ex_addr.push_back(6'd1); ex_data.push_back(vecs[v].w1); end
      settle();
      check_writes($sformatf("vec%0d", v));
      check($sformatf("vec%0d prog_loaded", v), prog_loaded, vecs[v].prog);
      check($sformatf("vec%0d frame_err", v), frame_err, vecs[v].err);
      check($sformatf("vec%0d core_ready", v), core_ready, 1);
      check($sformatf("vec%0d starts", v), start_cnt, exp_starts);
    end

    // Launch, stall during RUN, halt, relaunch
    send(8'h80, 1'b1);
    exp_starts++;
    check("run start pulse", core_start, 1);
    check("run ready low", core_ready, 0);
    msg_valid = 1'b1; mess_to_core = 8'h80; msg_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("run start one-shot", core_start, 0);
      check("run ready held low", core_ready, 0);
    end
    msg_valid = 1'b0;
    halt_pulse();
    check("halt ready back", core_ready, 1);
    check("run beat not consumed", frame_err, 0);
    send(8'h80, 1'b1);
    exp_starts++;
    check("relaunch start", core_start, 1);
    halt_pulse();
    settle();
    check("run start count", start_cnt, exp_starts);
    check("run prog kept", prog_loaded, 1);

    // START without a program
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(8'h80, 1'b1);
    settle();
    check("start noprog err", frame_err, 1);
    check("start noprog starts", start_cnt, exp_starts);
    check("start noprog ready", core_ready, 1);
    send(8'h00, 1'b1);
    settle();
    check("nop clears err", frame_err, 0);

    // Reset in the middle of a LOAD frame
    send(8'h40, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("async reset outputs", {core_ready, imem_we, prog_loaded, core_start, frame_err, imem_addr}, 32'h0);
    check("async reset wdata", imem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post reset ready", core_ready, 1);
    send(8'h40, 1'b0); send(8'h44, 1'b0); send(8'h33, 1'b0); send(8'h22, 1'b0); send(8'h11, 1'b1);
    ex_addr.push_back(6'd0); ex_data.push_back(32'h11223344);
    settle();
    check_writes("reload");
    check("reload prog", prog_loaded, 1);
    check("reload err", frame_err, 0);

    // Randomized frames against a frame-level model
    m_prog = 1'b1;
    for (int f = 0; f < 60; f++) begin
      cmd   = $urandom_range(0, 3);
      multi = ($urandom_range(0, 4) == 0);
      m_err = 1'b0;
      data.delete();
      if (cmd == 1) begin
        len  = $urandom_range(0, 3);
        need = (len + 1) * 4;
        kind = $urandom_range(0, 5);
        if (kind == 0) nd = 0;
        else if (kind == 1) begin
          nd = $urandom_range(1, need - 1);
          if (nd % 4 == 0) nd--;
        end
        else if (kind == 2) nd = need + $urandom_range(1, 3);
        else nd = need;
        hdr = {2'b01, 6'(len)};
        send(hdr, nd == 0);
        for (int i = 0; i < nd; i++) begin
          data.push_back(8'($urandom));
          gap();
          send(data[i], i == nd - 1);
        end
        if (nd == 0) m_err = 1'b1;
        else begin
          nwr = (nd >= need) ? len + 1 : nd / 4;
          for (int w = 0; w < nwr; w++) begin
            ex_addr.push_back(6'(w));
            ex_data.push_back({data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]});
          end
          m_err  = (nd != need);
          m_prog = (nd == need);
        end
      end else begin
        hdr = {2'(cmd), 6'($urandom)};
        send(hdr, !multi);
        if (multi) begin
          nx = $urandom_range(1, 3);
          for (int i = 0; i < nx; i++) begin
            gap();
            send(8'($urandom), i == nx - 1);
          end
          m_err = 1'b1;
        end else if (cmd == 2) begin
          if (m_prog) begin
            exp_starts++;
            check($sformatf("rnd%0d run ready", f), core_ready, 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            halt_pulse();
          end else m_err = 1'b1;
        end else if (cmd == 3) m_prog = 1'b0;
      end
      settle();
      check_writes($sformatf("rnd%0d", f));
      check($sformatf("rnd%0d prog_loaded", f), prog_loaded, m_prog);
      check($sformatf("rnd%0d frame_err", f), frame_err, m_err);
      check($sformatf("rnd%0d starts", f), start_cnt, exp_starts);
      check($sformatf("rnd%0d core_ready", f), core_ready, 1);
      gap();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
